i2s_to_parallel: RTL and testbench
==================================

Name: i2s_to_parallel

Overview:
I2S receiver and deserializer; the receive-side counterpart of the team's parallel-to-I2S transmitter.
- Samples SDATA on rising BCLK and frames channels with LRCLK (Philips I2S, one-bit delay, MSB first).
- Emits each completed left/right pair as two parallel words through a valid/ready handshake.
- Sits between the codec serial port and the audio datapath.

Parameters:
WORD_LEN, 16, bits captured per channel, MSB first. Bits beyond WORD_LEN in a slot are ignored.
LEFT_LEVEL, 0, LRCLK level that marks the left channel.
CNT_W, 6, bit-counter width. Must satisfy 2^CNT_W - 1 >= WORD_LEN.

Ports:
BCLK  input  1  bit clock; the only clock in the block, all logic on its rising edge
RST_N  input  1  asynchronous active-low reset
LRCLK  input  1  word select; changes on falling BCLK
SDATA  input  1  serial data; changes on falling BCLK
ready  input  1  downstream accepts the pair this cycle
ovr_clr  input  1  clears the overrun flag
left_out  output  WORD_LEN  left sample of the held pair
right_out  output  WORD_LEN  right sample of the held pair
valid  output  1  a pair is held in left_out/right_out
overrun  output  1  sticky: a completed pair was dropped
frame_err  output  1  sticky: a channel slot ended before WORD_LEN bits were captured

Behaviour:
- Reset (asynchronous, RST_N=0): state=SYNC, bit_cnt=0, shift register=0, lr_q=LRCLK-independent 0. All outputs 0 (left_out, right_out, valid, overrun, frame_err).
- Edge detect: lr_q is registered LRCLK. A channel edge is LRCLK != lr_q at a rising BCLK.
  - On an edge: SDATA is the delay bit and is ignored. bit_cnt<=0. cur_ch<=(LRCLK==LEFT_LEVEL ? L : R). State->SHIFT.
- States:
  - SYNC: entered after reset. Wait for the first channel edge; the half-frame in progress is discarded.
  - SHIFT: each non-edge rising BCLK does shift<={shift[WORD_LEN-2:0],SDATA} and bit_cnt++. When bit_cnt reaches WORD_LEN-1 and the final bit is sampled, the word is complete: latch it into hold_l or hold_r per cur_ch, then state->DONE.
  - DONE: ignore SDATA until the next edge, which returns to SHIFT.
- Short slot: an edge while in SHIFT (fewer than WORD_LEN bits captured) sets frame_err. The partial word is discarded, a latched left word is invalidated, and the edge proceeds as normal.
- Pairing:
  - A left completion sets l_ok.
  - A right completion with l_ok=1 forms a pair and clears l_ok.
  - A right completion without l_ok (e.g. after SYNC) is dropped silently; no flag is set.
- Output latency: valid rises on the rising BCLK one cycle after the right LSB is sampled. left_out/right_out change only when valid is loaded.
- Handshake:
  - valid&&ready transfers the pair.
  - valid deasserts the next cycle unless a new pair loads in the same cycle; in that case the new pair loads and valid stays 1.
  - Outputs are stable while valid&&!ready.
- Overrun: a new pair arriving while valid&&!ready is dropped; the old pair is held and overrun is set. overrun clears only on ovr_clr. If ovr_clr and a new overrun occur in the same cycle, set wins.
- frame_err clears only on reset.
- Reset mid-frame: reset is asynchronous; everything returns to SYNC and no partial pair is emitted.

Decomposition:
- Shared package i2s_pkg:
  - WORD_LEN default
  - channel constants CH_L=0, CH_R=1
  - state encoding SYNC=2'd0, SHIFT=2'd1, DONE=2'd2
  The transmitter adopts the same package.
- Sub-module i2s_shift_in: bit counter, shift register and word-complete strobe, with inputs edge/SDATA.
- The top level holds the FSM, pair holding registers, handshake and flags.

Test Plan:
1. Standard frames, WORD_LEN=16, 32 BCLK/slot, left=16'hA5C3, right=16'h1234, ready=1 -> valid for one cycle with left_out=A5C3 and right_out=1234, one BCLK after the right LSB; bits 17..31 ignored.
2. Start mid-right-slot after reset -> first right word dropped; first valid pair is the next complete L/R pair. overrun=0, frame_err=0.
3. ready=0 for two frames (pairs 0x0001/0x0002, then 0x0003/0x0004) -> outputs hold 0001/0002 and overrun=1. Then ready=1 -> transfer, and the next pair loads normally. ovr_clr pulse -> overrun=0.
4. ready=1 asserted in the same cycle a new pair completes -> old pair consumed, new pair loaded, valid stays 1 with no gap.
5. Left slot only 10 BCLKs long -> frame_err=1; no pair emitted for that frame; next full frame decodes correctly.
6. RST_N low mid-left-word with valid=1 -> all outputs 0 immediately. After release, state is SYNC and decoding resumes from the next edge.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default word length, channel tags and the receive state encoding.
// Used by both the I2S receiver and the parallel-to-I2S transmitter.
package i2s_pkg;

  localparam int DEF_WORD_LEN = 16;

  typedef enum logic {
    CH_L = 1'b0,
    CH_R = 1'b1
  } channelT;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rxStateT;

endpackage

// File: rtl/i2s_to_parallel_if.sv
// Serial-in / parallel-out bundle of the I2S receiver.
// The master side drives serial data and the handshake; the slave side is the receiver.
interface i2s_to_parallel_if
  import i2s_pkg::*;
#(
    parameter int WORD_LEN = DEF_WORD_LEN
);

    logic                LRCLK;
    logic                SDATA;
    logic                ready;
    logic                ovr_clr;
    logic [WORD_LEN-1:0] left_out;
    logic [WORD_LEN-1:0] right_out;
    logic                valid;
    logic                overrun;
    logic                frame_err;

    modport master (
        output LRCLK, SDATA, ready, ovr_clr,
        input  left_out, right_out, valid, overrun, frame_err
    );

    modport slave (
        input  LRCLK, SDATA, ready, ovr_clr,
        output left_out, right_out, valid, overrun, frame_err
    );

endinterface

// File: rtl/i2s_shift_in.sv
// Bit counter and MSB-first shift register for one channel slot.
// wordDone strobes on the edge that samples the final bit; word is valid in that same cycle.
module i2s_shift_in
    import i2s_pkg::*;
#(
    parameter int WORD_LEN = DEF_WORD_LEN,
    parameter int CNT_W    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                chEdge,
    input  logic                shiftEn,
    input  logic                sdata,
    output logic [WORD_LEN-1:0] word,
    output logic                wordDone
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LEN - 1);

    logic [WORD_LEN-2:0] shiftReg;
    logic [CNT_W-1:0]    bitCnt;

    assign word     = {shiftReg, sdata};
    assign wordDone = shiftEn && !chEdge && (bitCnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shiftReg <= '0;
            bitCnt   <= '0;
        end else if (chEdge) begin
            // The edge cycle carries the I2S delay bit, so nothing is shifted in.
            bitCnt <= '0;
        end else if (shiftEn) begin
            shiftReg <= word[WORD_LEN-2:0];
            bitCnt   <= bitCnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_to_parallel.sv
// Philips I2S receiver: frames slots on LRCLK edges, pairs left/right words and
// presents each pair on a valid/ready port with sticky overrun and framing flags.
module i2s_to_parallel
    import i2s_pkg::*;
#(
    parameter int   WORD_LEN   = DEF_WORD_LEN,
    parameter logic LEFT_LEVEL = 1'b0,
    parameter int   CNT_W      = 6
) (
    input logic               BCLK,
    input logic               RST_N,
    i2s_to_parallel_if.slave  bus
);

    rxStateT             state;
    channelT             curCh;
    logic                lrQ;
    logic                lOk;
    logic                pairPend;
    logic [WORD_LEN-1:0] holdL;
    logic [WORD_LEN-1:0] holdR;
    logic [WORD_LEN-1:0] word;
    logic                chEdge;
    logic                shiftEn;
    logic                wordDone;
    logic                stalled;

    assign chEdge  = (bus.LRCLK != lrQ);
    assign shiftEn = (state == SHIFT);
    assign stalled = bus.valid && !bus.ready;

    i2s_shift_in #(
        .WORD_LEN(WORD_LEN),
        .CNT_W   (CNT_W)
    ) u_shiftIn (
        .clk     (BCLK),
        .rst_n   (RST_N),
        .chEdge  (chEdge),
        .shiftEn (shiftEn),
        .sdata   (bus.SDATA),
        .word    (word),
        .wordDone(wordDone)
    );

    // Slot framing, word capture and left/right pairing.
    always_ff @(posedge BCLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= SYNC;
            curCh         <= CH_L;
            lrQ           <= 1'b0;
            lOk           <= 1'b0;
            pairPend      <= 1'b0;
            holdL         <= '0;
            holdR         <= '0;
            bus.frame_err <= 1'b0;
        end else begin
            lrQ      <= bus.LRCLK;
            // NOTE: a default before the branches keeps pairPend a one-cycle pulse
            // without repeating the clear in every path.
            pairPend <= 1'b0;
            if (chEdge) begin
                if (state == SHIFT) begin
                    bus.frame_err <= 1'b1;
                    lOk           <= 1'b0;
                end
                state <= SHIFT;
                curCh <= (bus.LRCLK == LEFT_LEVEL) ? CH_L : CH_R;
            end else if (wordDone) begin
                state <= DONE;
                if (curCh == CH_L) begin
                    holdL <= word;
                    lOk   <= 1'b1;
                end else begin
                    holdR <= word;
                    if (lOk) begin
                        pairPend <= 1'b1;
                        lOk      <= 1'b0;
                    end
                end
            end
        end
    end

    // Output pair register and handshake; a pair arriving while stalled is dropped.
    always_ff @(posedge BCLK or negedge RST_N) begin
        if (!RST_N) begin
            bus.left_out  <= '0;
            bus.right_out <= '0;
            bus.valid     <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            if (pairPend && stalled) begin
                bus.overrun <= 1'b1;
            end else if (bus.ovr_clr) begin
                bus.overrun <= 1'b0;
            end

            if (pairPend && !stalled) begin
                bus.left_out  <= holdL;
                bus.right_out <= holdR;
                bus.valid     <= 1'b1;
            end else if (bus.valid && bus.ready) begin
                bus.valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_to_parallel.sv
// Directed and randomized bench for i2s_to_parallel: drives I2S slots bit by bit and
// checks pairs, latency, handshake and flags against expectations derived from the slots sent.
module tb_i2s_to_parallel;

    localparam int WL = 16;

    logic BCLK = 1'b0;
    logic RST_N;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   validSeen;

    i2s_to_parallel_if #(.WORD_LEN(WL)) bus ();

    i2s_to_parallel #(
        .WORD_LEN  (WL),
        .LEFT_LEVEL(1'b0),
        .CNT_W     (6)
    ) dut (
        .BCLK (BCLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 BCLK = ~BCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One BCLK period: inputs change on the falling edge, outputs sampled 1 ns after the rising edge.
    task automatic bit_cycle(input logic lr, input logic sd);
        @(negedge BCLK);
        bus.LRCLK = lr;
        bus.SDATA = sd;
        @(posedge BCLK);
        #1;
        if (bus.valid === 1'b1) validSeen = 1'b1;
    endtask

    // A slot of len BCLKs: delay bit, then data MSB first, then filler that must be ignored.
    task automatic send_slot(input logic lr, input logic [WL-1:0] data, input int len);
        for (int i = 0; i < len; i++) begin
            if (i >= 1 && i <= WL) bit_cycle(lr, data[WL-i]);
            else bit_cycle(lr, 1'($urandom));
        end
    endtask

    task automatic send_tail(input logic lr, input int n);
        for (int i = 0; i < n; i++) bit_cycle(lr, 1'($urandom));
    endtask

    // Right slot of a complete frame with ready=1: checks valid exactly one BCLK after the LSB.
    task automatic right_checked(input string pre, input logic [WL-1:0] expL,
                                 input logic [WL-1:0] expR, input int len);
        send_slot(1'b1, expR, WL + 1);
        check({pre, " valid at LSB"}, bus.valid, 0);
        send_tail(1'b1, 1);
        check({pre, " valid"}, bus.valid, 1);
        check({pre, " left_out"}, bus.left_out, expL);
        check({pre, " right_out"}, bus.right_out, expR);
        send_tail(1'b1, 1);
        check({pre, " valid after xfer"}, bus.valid, 0);
        send_tail(1'b1, len - WL - 3);
    endtask

    task automatic check_all_zero(input string pre);
        check({pre, " valid"}, bus.valid, 0);
        check({pre, " left_out"}, bus.left_out, 0);
        check({pre, " right_out"}, bus.right_out, 0);
        check({pre, " overrun"}, bus.overrun, 0);
        check({pre, " frame_err"}, bus.frame_err, 0);
    endtask

    initial begin
        logic [WL-1:0] l, r, c, d;
        int            lLen, rLen;
        bit            expPair, errExp;

        bus.LRCLK   = 1'b0;
        bus.SDATA   = 1'b0;
        bus.ready   = 1'b1;
        bus.ovr_clr = 1'b0;
        RST_N       = 1'b0;
        repeat (3) @(posedge BCLK);
        #1;
        check_all_zero("reset");
        @(negedge BCLK);
        RST_N = 1'b1;

        // Standard frame: 32 BCLK slots, filler bits after the LSB ignored.
        validSeen = 1'b0;
        send_slot(1'b1, 16'($urandom), 32);
        send_slot(1'b0, 16'hA5C3, 32);
        check("t1 no early pair", validSeen, 0);
        right_checked("t1", 16'hA5C3, 16'h1234, 32);
        check("t1 frame_err", bus.frame_err, 0);

        // Reset released in the middle of a right slot.
        @(negedge BCLK);
        bus.LRCLK = 1'b1;
        RST_N     = 1'b0;
        @(posedge BCLK);
        @(negedge BCLK);
        RST_N     = 1'b1;
        validSeen = 1'b0;
        send_tail(1'b1, 24);
        l = 16'($urandom);
        r = 16'($urandom);
        send_slot(1'b0, l, 32);
        check("t2 partial right dropped", validSeen, 0);
        right_checked("t2", l, r, 32);
        check("t2 overrun", bus.overrun, 0);
        check("t2 frame_err", bus.frame_err, 0);

        // Two pairs with ready low: first is held, second dropped with overrun.
        bus.ready = 1'b0;
        send_slot(1'b0, 16'h0001, 32);
        send_slot(1'b1, 16'h0002, WL + 1);
        send_tail(1'b1, 1);
        check("t3 valid", bus.valid, 1);
        check("t3 left", bus.left_out, 16'h0001);
        check("t3 right", bus.right_out, 16'h0002);
        send_tail(1'b1, 14);
        send_slot(1'b0, 16'h0003, 32);
        send_slot(1'b1, 16'h0004, WL + 1);
        send_tail(1'b1, 1);
        check("t3 held valid", bus.valid, 1);
        check("t3 held left", bus.left_out, 16'h0001);
        check("t3 held right", bus.right_out, 16'h0002);
        check("t3 overrun set", bus.overrun, 1);
        send_tail(1'b1, 14);
        bus.ready = 1'b1;
        send_tail(1'b1, 1);
        check("t3 transferred", bus.valid, 0);
        check("t3 overrun sticky", bus.overrun, 1);
        send_slot(1'b0, 16'h0005, 32);
        right_checked("t3 next", 16'h0005, 16'h0006, 32);
        bus.ovr_clr = 1'b1;
        send_tail(1'b1, 1);
        bus.ovr_clr = 1'b0;
        check("t3 overrun cleared", bus.overrun, 0);

        // ready rises in the cycle a new pair loads: back-to-back with no gap.
        l = 16'($urandom); r = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
        bus.ready = 1'b0;
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, WL + 1);
        send_tail(1'b1, 1);
        check("t4 first valid", bus.valid, 1);
        send_tail(1'b1, 14);
        send_slot(1'b0, c, 32);
        send_slot(1'b1, d, WL + 1);
        check("t4 old still held", bus.left_out, l);
        bus.ready = 1'b1;
        send_tail(1'b1, 1);
        check("t4 valid no gap", bus.valid, 1);
        check("t4 new left", bus.left_out, c);
        check("t4 new right", bus.right_out, d);
        check("t4 no overrun", bus.overrun, 0);
        send_tail(1'b1, 1);
        check("t4 consumed", bus.valid, 0);
        send_tail(1'b1, 13);

        // Short left slot of 10 BCLKs.
        validSeen = 1'b0;
        send_slot(1'b0, 16'($urandom), 10);
        send_slot(1'b1, 16'($urandom), 32);
        check("t5 frame_err", bus.frame_err, 1);
        check("t5 no pair", validSeen, 0);
        l = 16'($urandom);
        r = 16'($urandom);
        send_slot(1'b0, l, 32);
        right_checked("t5 recover", l, r, 32);

        // Asynchronous reset in the middle of a left word with a pair held.
        bus.ready = 1'b0;
        send_slot(1'b0, 16'($urandom), 32);
        send_slot(1'b1, 16'($urandom), WL + 1);
        send_tail(1'b1, 1);
        check("t6 pair held", bus.valid, 1);
        send_tail(1'b1, 14);
        send_tail(1'b0, 8);
        RST_N = 1'b0;
        #1;
        check_all_zero("t6 async");
        send_tail(1'b0, 2);
        #1;
        RST_N     = 1'b1;
        bus.ready = 1'b1;
        validSeen = 1'b0;
        send_tail(1'b0, 20);
        send_slot(1'b1, 16'($urandom), 32);
        check("t6 no pair after reset", validSeen, 0);
        check("t6 frame_err", bus.frame_err, 0);
        l = 16'($urandom);
        r = 16'($urandom);
        send_slot(1'b0, l, 32);
        right_checked("t6 resume", l, r, 32);

        // Random frames: a left slot shorter than WL+1 BCLKs cannot hold a word,
        // so that frame yields no pair and latches frame_err for good.
        errExp = 1'b0;
        for (int f = 0; f < 12; f++) begin
            lLen      = $urandom_range(8, 32);
            rLen      = $urandom_range(WL + 3, 32);
            l         = 16'($urandom);
            r         = 16'($urandom);
            expPair   = (lLen > WL);
            errExp    = errExp | !expPair;
            validSeen = 1'b0;
            send_slot(1'b0, l, lLen);
            check("rnd no early pair", validSeen, 0);
            send_slot(1'b1, r, WL + 1);
            check("rnd valid at LSB", bus.valid, 0);
            send_tail(1'b1, 1);
            check("rnd valid", bus.valid, 32'(expPair));
            if (expPair) begin
                check("rnd left", bus.left_out, l);
                check("rnd right", bus.right_out, r);
            end
            check("rnd frame_err", bus.frame_err, 32'(errExp));
            send_tail(1'b1, rLen - WL - 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
